// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: sweeps the four {a,b} operand combinations through an
// external basic-gates unit, lets each vector settle, captures the unit's
// seven outputs and compares them against the known-good truth table.
// Results (pass, fail_vec, err_mask, cap_z) stay stable until the next run.
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        gate_a,
    output logic        gate_b,
    input  logic [6:0]  gate_z,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_vec,
    output logic [6:0]  err_mask,
    output logic [27:0] cap_z
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [3:0]  fail_s;
    logic [6:0]  err_s;
    logic [27:0] cap_s;
    logic        pass_s;
    logic [6:0]  diff_s;
    logic        run_s;

    // Expected unit output for operands {a,b}:
    // bit order {not a, xnor, xor, nor, nand, or, and}.
    function automatic logic [6:0] golden(input logic [1:0] ab);
        logic [6:0] g;
        case (ab)
            2'b00:   g = 7'h6C;
            2'b01:   g = 7'h56;
            2'b10:   g = 7'h16;
            2'b11:   g = 7'h23;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    assign diff_s = gate_z ^ golden(idx_r);
    assign run_s  = (state_s == DRIVE) || (state_s == SAMPLE);

    // Next-state logic plus next values of the result registers.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        fail_s  = fail_vec;
        err_s   = err_mask;
        cap_s   = cap_z;
        pass_s  = pass;
        case (state_r)
            IDLE: begin
                // abort outranks start, so a simultaneous pair starts nothing
                if (start && !abort) begin
                    state_s = DRIVE;
                    idx_s   = 2'd0;
                    cnt_s   = 4'd0;
                    fail_s  = 4'h0;
                    err_s   = 7'h00;
                    cap_s   = 28'h0000000;
                    pass_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_s = IDLE;
                    pass_s  = 1'b0;
                end else if (cnt_r == 4'(SETTLE_CYCLES - 1)) begin
                    state_s = SAMPLE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    // partial results are kept; this vector is not captured
                    state_s = IDLE;
                    pass_s  = 1'b0;
                end else begin
                    case (idx_r)
                        2'd0:    cap_s[6:0]   = gate_z;
                        2'd1:    cap_s[13:7]  = gate_z;
                        2'd2:    cap_s[20:14] = gate_z;
                        default: cap_s[27:21] = gate_z;
                    endcase
                    fail_s[idx_r] = fail_vec[idx_r] | (diff_s != 7'h00);
                    err_s         = err_mask | diff_s;
                    if (idx_r == 2'd3) begin
                        // pass lands on the same edge as done
                        state_s = DONE;
                        pass_s  = (fail_s == 4'h0);
                    end else begin
                        state_s = DRIVE;
                        idx_s   = idx_r + 2'd1;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters, results and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= 2'd0;
            cnt_r    <= 4'd0;
            fail_vec <= 4'h0;
            err_mask <= 7'h00;
            cap_z    <= 28'h0000000;
            pass     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            cnt_r    <= cnt_s;
            fail_vec <= fail_s;
            err_mask <= err_s;
            cap_z    <= cap_s;
            pass     <= pass_s;
            busy     <= run_s;
            done     <= (state_s == DONE);
            gate_a   <= run_s ? idx_s[1] : 1'b0;
            gate_b   <= run_s ? idx_s[0] : 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: one instance with one settle cycle,
// one with three settle cycles, each fed by a behavioural gate model.
module tb_gate_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start1, abort1, ga1, gb1, busy1, done1, pass1;
    logic [6:0]  z1, err1;
    logic [3:0]  fv1;
    logic [27:0] cap1;
    logic        start3, abort3, ga3, gb3, busy3, done3, pass3;
    logic [6:0]  z3, err3;
    logic [3:0]  fv3;
    logic [27:0] cap3;
    logic        xor_stuck;
    logic        corrupt3;
    logic [27:0] exp_cap;
    int          n_cmp;
    int          n_bad;

    gate_sweep_ctrl dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .gate_a(ga1), .gate_b(gb1), .gate_z(z1), .busy(busy1),
        .done(done1), .pass(pass1), .fail_vec(fv1), .err_mask(err1),
        .cap_z(cap1)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .gate_a(ga3), .gate_b(gb3), .gate_z(z3), .busy(busy3),
        .done(done3), .pass(pass3), .fail_vec(fv3), .err_mask(err3),
        .cap_z(cap3)
    );

    // Behavioural basic-gates unit, built from the logic operations themselves.
    function automatic logic [6:0] gmodel(input logic a, input logic b);
        return {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    assign z1 = gmodel(ga1, gb1) & (xor_stuck ? 7'h6F : 7'h7F);
    assign z3 = gmodel(ga3, gb3) ^ (corrupt3 ? 7'h7F : 7'h00);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({busy1, done1, pass1, ga1, gb1, fv1, err1, cap1} !== 43'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b cap=%h want all 0", busy1, done1, pass1, cap1);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle got busy1=%b busy3=%b want 0", busy1, busy3);
        end
    endtask

    // Runs a sweep on dut1 and checks done timing plus results.
    task automatic run_sweep(input string name, input logic [3:0] efv,
                             input logic [6:0] eerr, input logic epass,
                             input logic [27:0] ecap);
        int ndone;
        int dcyc;
        ndone = 0;
        dcyc  = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1 && ({ga1, gb1} !== 2'b00 || busy1 !== 1'b1)) begin
                n_bad++;
                $display("FAIL %s_first_cycle got busy=%b ab=%b%b want busy=1 ab=00", name, busy1, ga1, gb1);
            end
            if (k == 3 && {ga1, gb1} !== 2'b01) begin
                n_bad++;
                $display("FAIL %s_vec1_drive got ab=%b%b want 01", name, ga1, gb1);
            end
            if (done1 === 1'b1) begin
                ndone++;
                dcyc = k;
            end
            tick();
        end
        n_cmp += 2;
        n_cmp++;
        if (ndone !== 1 || dcyc !== 9) begin
            n_bad++;
            $display("FAIL %s_done got %0d pulses at N+%0d want 1 at N+9", name, ndone, dcyc);
        end
        n_cmp++;
        if (pass1 !== epass) begin
            n_bad++;
            $display("FAIL %s_pass got %b want %b", name, pass1, epass);
        end
        n_cmp++;
        if (fv1 !== efv || err1 !== eerr) begin
            n_bad++;
            $display("FAIL %s_fail got fv=%b err=%h want fv=%b err=%h", name, fv1, err1, efv, eerr);
        end
        n_cmp++;
        if (cap1 !== ecap) begin
            n_bad++;
            $display("FAIL %s_cap got %h want %h", name, cap1, ecap);
        end
    endtask

    task automatic test_good_sweep();
        xor_stuck = 1'b0;
        run_sweep("good", 4'b0000, 7'h00, 1'b1, exp_cap);
        n_cmp++;
        if (exp_cap !== 28'h465AB6C) begin
            n_bad++;
            $display("FAIL good_model got %h want 465ab6c", exp_cap);
        end
    endtask

    task automatic test_xor_stuck();
        xor_stuck = 1'b1;
        run_sweep("xor_stuck", 4'b0110, 7'h10, 1'b0, exp_cap & 28'hDFBF7EF);
        xor_stuck = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ndone;
        int dcyc;
        ndone = 0;
        dcyc  = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            start1 = (k == 3) || (k == 8) || (k == 9);
            if (done1 === 1'b1) begin
                ndone++;
                dcyc = k;
            end
            if (k >= 11) begin
                n_cmp++;
                if (busy1 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_no_restart cycle N+%0d got busy=%b want 0", k, busy1);
                end
            end
            tick();
        end
        start1 = 1'b0;
        n_cmp++;
        if (ndone !== 1 || dcyc !== 9) begin
            n_bad++;
            $display("FAIL b2b_done got %0d pulses at N+%0d want 1 at N+9", ndone, dcyc);
        end
    endtask

    task automatic test_abort();
        int ndone;
        ndone = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            abort1 = (k == 4);
            if (done1 === 1'b1) ndone++;
            if (k >= 5) begin
                n_cmp++;
                if (busy1 !== 1'b0 || {ga1, gb1} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL abort_idle cycle N+%0d got busy=%b ab=%b%b want 0 00", k, busy1, ga1, gb1);
                end
            end
            tick();
        end
        abort1 = 1'b0;
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL abort_done got %0d pulses want 0", ndone);
        end
        n_cmp++;
        if (pass1 !== 1'b0 || cap1 !== 28'h000006C || fv1 !== 4'h0 || err1 !== 7'h00) begin
            n_bad++;
            $display("FAIL abort_held got pass=%b cap=%h fv=%b err=%h want 0 000006c 0 00", pass1, cap1, fv1, err1);
        end
    endtask

    task automatic test_async_reset();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy1, done1, pass1, ga1, gb1, fv1, err1, cap1} !== 43'h0) begin
            n_bad++;
            $display("FAIL async_reset got busy=%b ab=%b%b cap=%h want all 0", busy1, ga1, gb1, cap1);
        end
        #1;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_idle got busy=%b want 0", busy1);
        end
        run_sweep("after_reset", 4'b0000, 7'h00, 1'b1, exp_cap);
    endtask

    task automatic test_settle3();
        int ndone;
        int dcyc;
        ndone = 0;
        dcyc  = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            corrupt3 = (k <= 16) && (((k - 1) % 4) < 2);
            if (done3 === 1'b1) begin
                ndone++;
                dcyc = k;
            end
            tick();
        end
        corrupt3 = 1'b0;
        n_cmp++;
        if (ndone !== 1 || dcyc !== 17) begin
            n_bad++;
            $display("FAIL settle3_done got %0d pulses at N+%0d want 1 at N+17", ndone, dcyc);
        end
        n_cmp++;
        if (pass3 !== 1'b1 || fv3 !== 4'h0 || cap3 !== exp_cap) begin
            n_bad++;
            $display("FAIL settle3_result got pass=%b fv=%b cap=%h want 1 0 %h", pass3, fv3, cap3, exp_cap);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        start3 = 1'b0;
        abort3 = 1'b0;
        xor_stuck = 1'b0;
        corrupt3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            exp_cap[7*i +: 7] = gmodel(ab[1], ab[0]);
        end
        test_reset();
        test_good_sweep();
        test_xor_stuck();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_settle3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
